// File: rtl/axi_xbar_rr_arbiter_if.sv
// Request/grant bundle between crossbar requesters and one output arbiter.
// master drives requests and acknowledges; slave (the arbiter) drives grants.
interface axi_xbar_rr_arbiter_if #(
    parameter int PORTS = 4,
    parameter int CL    = (PORTS > 1) ? $clog2(PORTS) : 1
);
    logic [PORTS-1:0] request;
    logic [PORTS-1:0] acknowledge;
    logic [PORTS-1:0] grant;
    logic             grant_valid;
    logic [CL-1:0]    grant_encoded;

    modport master (
        output request,
        output acknowledge,
        input  grant,
        input  grant_valid,
        input  grant_encoded
    );

    modport slave (
        input  request,
        input  acknowledge,
        output grant,
        output grant_valid,
        output grant_encoded
    );
endinterface

// File: rtl/axi_xbar_rr_arbiter.sv
// Round-robin arbiter for one crossbar output channel, registered grant.
// Define ARB_BURST_EN to keep a grant for up to BURST_MAX acknowledges.
module axi_xbar_rr_arbiter #(
    parameter int PORTS     = 4,
    parameter int BURST_MAX = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    axi_xbar_rr_arbiter_if.slave  arb
);
    localparam int CL = (PORTS > 1) ? $clog2(PORTS) : 1;

    if (PORTS < 1 || PORTS > 32) begin : g_bad_ports
        $error("PORTS must be in 1..32");
    end
    if (BURST_MAX < 1) begin : g_bad_burst
        $error("BURST_MAX must be >= 1");
    end

    typedef enum logic {IDLE, GRANTED} state_t;

    state_t           state_q, state_d;
    logic [PORTS-1:0] grant_q, grant_d;
    logic [CL-1:0]    enc_q, enc_d;
    logic [CL-1:0]    last_q, last_d;
    logic [PORTS-1:0] win_oh;
    logic [CL-1:0]    win_idx;
    logic             win_any;
    logic             take;

`ifdef ARB_BURST_EN
    localparam int CW = $clog2(BURST_MAX + 1);
    logic [CW-1:0]    cnt_q, cnt_d;
`endif

    // Search starts just after the last winner, so it ends on last itself.
    always_comb begin : rr_pick
        int idx;
        win_oh  = '0;
        win_idx = '0;
        win_any = 1'b0;
        for (int i = 1; i <= PORTS; i++) begin
            idx = (int'(last_q) + i) % PORTS;
            if (!win_any && arb.request[idx]) begin
                win_any      = 1'b1;
                win_oh[idx]  = 1'b1;
                win_idx      = CL'(idx);
            end
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        grant_d = grant_q;
        enc_d   = enc_q;
        last_d  = last_q;
        take    = 1'b0;
`ifdef ARB_BURST_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: take = win_any;
            GRANTED: begin
                if (!arb.request[enc_q]) begin
                    take = 1'b1;
                end else if (arb.acknowledge[enc_q]) begin
`ifdef ARB_BURST_EN
                    if (int'(cnt_q) + 1 < BURST_MAX)
                        cnt_d = cnt_q + 1'b1;
                    else if ((arb.request & ~grant_q) != '0)
                        take = 1'b1;
                    else
                        cnt_d = '0;
`else
                    take = 1'b1;
`endif
                end
            end
        endcase
        // Release and re-grant share one edge: no idle bubble.
        if (take) begin
            state_d = win_any ? GRANTED : IDLE;
            grant_d = win_oh;
            enc_d   = win_idx;
            if (win_any)
                last_d = win_idx;
`ifdef ARB_BURST_EN
            cnt_d   = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            enc_q   <= '0;
            last_q  <= CL'(PORTS - 1);
`ifdef ARB_BURST_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            enc_q   <= enc_d;
            last_q  <= last_d;
`ifdef ARB_BURST_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign arb.grant         = grant_q;
    assign arb.grant_valid   = (state_q == GRANTED);
    assign arb.grant_encoded = enc_q;
endmodule

// File: tb/tb_axi_xbar_rr_arbiter.sv
// Bench for axi_xbar_rr_arbiter: directed vectors, queue-free index model.
// Burst checks run when ARB_BURST_EN is defined.
module tb_axi_xbar_rr_arbiter;
    localparam int P  = 4;
    localparam int BM = 2;

    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    axi_xbar_rr_arbiter_if #(.PORTS(P)) bus ();

    axi_xbar_rr_arbiter #(
        .PORTS     (P),
        .BURST_MAX (BM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b want %0b at %0t", nm, got, exp,
                     $time);
        end
    endtask

    // Model: granted index as an integer, -1 meaning nobody holds it.
    int m_g    = -1;
    int m_last = P - 1;
    int m_cnt  = 0;

    function automatic int rr(input logic [P-1:0] r, input int last);
        for (int k = 1; k <= P; k++) begin
            int i;
            i = (last + k) % P;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit rel;
        logic [P-1:0] rq;
        logic [P-1:0] others;
        if (!rst_n) begin
            m_g    = -1;
            m_last = P - 1;
            m_cnt  = 0;
        end else begin
            rq  = bus.request;
            rel = (m_g < 0);
            if (m_g >= 0) begin
                others = rq & ~(P'(1) << m_g);
                if (!rq[m_g]) rel = 1;
                else if (bus.acknowledge[m_g]) begin
`ifdef ARB_BURST_EN
                    m_cnt = m_cnt + 1;
                    if (m_cnt >= BM) begin
                        if (others != 0) rel = 1;
                        else m_cnt = 0;
                    end
`else
                    rel = 1;
`endif
                end
            end
            if (rel) begin
                m_g = rr(rq, m_last);
                m_cnt = 0;
                if (m_g >= 0) m_last = m_g;
            end
        end
    end

    always @(negedge clk) begin
        logic [P-1:0] eg;
        eg = (m_g < 0) ? '0 : P'(1) << m_g;
        chk("model_grant", 32'(bus.grant), 32'(eg));
        chk("model_valid", 32'(bus.grant_valid), 32'(m_g >= 0));
        chk("model_enc", 32'(bus.grant_encoded),
            (m_g < 0) ? 32'd0 : 32'(m_g));
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [P-1:0] r, input logic [P-1:0] a);
        bus.request     = r;
        bus.acknowledge = a;
    endtask

    task automatic lit(input string nm, input logic [P-1:0] g,
                       input logic v, input logic [1:0] e);
        chk({nm, "_grant"}, 32'(bus.grant), 32'(g));
        chk({nm, "_valid"}, 32'(bus.grant_valid), 32'(v));
        chk({nm, "_enc"}, 32'(bus.grant_encoded), 32'(e));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive('0, '0);
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    logic [P-1:0] vr [12];
    logic [P-1:0] va [12];
    logic [P-1:0] seq [4];

    initial begin
        rst_n = 1'b0;
        drive('0, '0);
        cyc();
        cyc();
        rst_n = 1'b1;

        drive(4'b0001, 4'b0000);
        cyc();
        lit("latency", 4'b0001, 1'b1, 2'd0);
        drive(4'b0001, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            cyc();
            lit("sole_reack", 4'b0001, 1'b1, 2'd0);
        end
        drive(4'b0000, 4'b0000);
        cyc();
        lit("idle_after", 4'b0000, 1'b0, 2'd0);

`ifndef ARB_BURST_EN
        do_reset();
        drive(4'b1111, 4'b0000);
        cyc();
        lit("fair0", 4'b0001, 1'b1, 2'd0);
        seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        drive(4'b1111, 4'b1111);
        for (int i = 0; i < 4; i++) begin
            cyc();
            lit("fair", seq[i], 1'b1, 2'((i + 1) % 4));
        end

        drive(4'b0010, 4'b0001);
        cyc();
        lit("hand_pre", 4'b0010, 1'b1, 2'd1);
        drive(4'b0101, 4'b0010);
        cyc();
        lit("handoff", 4'b0100, 1'b1, 2'd2);
        drive(4'b0101, 4'b1000);
        cyc();
        lit("stray_ack", 4'b0100, 1'b1, 2'd2);
`endif

        drive(4'b0000, 4'b0000);
        cyc();
        lit("drop", 4'b0000, 1'b0, 2'd0);
        drive(4'b0000, 4'b1111);
        cyc();
        lit("idle_ack", 4'b0000, 1'b0, 2'd0);

        drive(4'b0100, 4'b0000);
        cyc();
        lit("pre_rst", 4'b0100, 1'b1, 2'd2);
        rst_n = 1'b0;
        #1;
        lit("async_rst", 4'b0000, 1'b0, 2'd0);
        drive(4'b1111, 4'b0000);
        cyc();
        rst_n = 1'b1;
        cyc();
        lit("post_rst", 4'b0001, 1'b1, 2'd0);

`ifdef ARB_BURST_EN
        do_reset();
        drive(4'b0011, 4'b0000);
        cyc();
        lit("burst0", 4'b0001, 1'b1, 2'd0);
        seq = '{4'b0001, 4'b0010, 4'b0010, 4'b0001};
        drive(4'b0011, 4'b1111);
        for (int i = 0; i < 4; i++) begin
            cyc();
            lit("burst", seq[i], 1'b1, (i == 1 || i == 2) ? 2'd1 : 2'd0);
        end
`endif

        vr = '{4'b1010, 4'b1010, 4'b1010, 4'b0110, 4'b0110, 4'b1001,
               4'b1001, 4'b0000, 4'b1111, 4'b1111, 4'b0111, 4'b1000};
        va = '{4'b0000, 4'b0010, 4'b1000, 4'b0100, 4'b0000, 4'b0001,
               4'b1111, 4'b0000, 4'b0101, 4'b1111, 4'b0100, 4'b0000};
        for (int i = 0; i < 12; i++) begin
            drive(vr[i], va[i]);
            cyc();
        end
        drive('0, '0);
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
